tensor_operand_loader: RTL and testbench
========================================

Name: tensor_operand_loader

Overview:
- Upstream feeder for the tensor unit.
- Collects A/B operand elements written by the core into a local staging buffer.
- On a start request it pulses tensor_load_start and streams the elements on consecutive cycles into the tensor unit's data_in_a/data_in_b.
- It then holds off new writes until the tensor unit reports load and store completion.

Parameters:
- NUM_ELEMS, 4, operand elements per matrix (power of 2, >=2).
- DATA_WIDTH, 32, element width in bits.
- TIMEOUT_CYCLES, 256, completion-wait limit; used only when TENSOR_LOADER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- wr_valid  in  1  element write strobe.
- wr_sel  in  1  0 = matrix A, 1 = matrix B.
- wr_idx  in  log2(NUM_ELEMS)  element index.
- wr_data  in  DATA_WIDTH  element value.
- wr_ready  out  1  write accepted this cycle.
- start_req  in  1  request to launch a load.
- start_ack  out  1  1-cycle pulse: launch accepted.
- start_nack  out  1  1-cycle pulse: launch rejected, operands incomplete.
- busy  out  1  high from launch until return to IDLE.
- operands_full  out  1  every A and B element has been written since the last launch.
- tensor_load_start  out  1  1-cycle launch pulse to the tensor unit.
- data_out_a  out  DATA_WIDTH  streamed A element.
- data_out_b  out  DATA_WIDTH  streamed B element.
- tensor_load_done  in  1  tensor unit finished loading.
- tensor_store_done  in  1  tensor unit finished storing results.
- timeout_err  out  1  sticky timeout flag; tied 0 when the optional feature is absent.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - State = IDLE; stream counter = 0.
  - Written masks (A and B, NUM_ELEMS bits each) = 0.
  - Buffer contents are don't-care.
- Reset mid-operation: takes effect on the next edge from any state and discards any in-flight stream.
- Writes:
  - wr_ready = 1 only in IDLE.
  - A write occurs when wr_valid && wr_ready. It stores wr_data at [wr_sel][wr_idx] and sets the matching mask bit.
  - Rewriting an index overwrites the data; the mask bit stays set.
- operands_full = &mask_a && &mask_b, registered from the masks.
- States:
  - IDLE:
    - start_req with operands_full = 1: start_ack = 1 next cycle; go to LAUNCH.
    - start_req with operands_full = 0: start_nack = 1 next cycle; stay in IDLE.
    - start_req and wr_valid in the same cycle: the write is committed first, and the start decision uses the pre-write operands_full.
  - LAUNCH (1 cycle): tensor_load_start = 1; busy = 1. Go to STREAM.
  - STREAM (NUM_ELEMS cycles):
    - data_out_a/b = buffer[k], with k = 0..NUM_ELEMS-1 on successive cycles, starting the cycle after the tensor_load_start pulse.
    - After k = NUM_ELEMS-1, go to WAIT_LOAD.
    - Outside STREAM, data_out_a/b = 0.
  - WAIT_LOAD: wait for tensor_load_done = 1, then go to WAIT_STORE.
    - A tensor_load_done seen during STREAM is latched and satisfies WAIT_LOAD on entry; no extra cycle.
  - WAIT_STORE: wait for tensor_store_done = 1, then go to IDLE.
    - On this transition clear both masks; busy falls in the same edge.
    - A tensor_store_done seen before WAIT_STORE is latched likewise.
- start_req while busy: ignored; no ack or nack.
- Latency: start_req sampled at edge N gives:
  - start_ack high in cycle N+1.
  - tensor_load_start high in cycle N+2.
  - element 0 in cycle N+3.
  - last element in cycle N+2+NUM_ELEMS.
- The stream counter wraps to 0 on leaving STREAM.

Optional Feature:
- Macro: TENSOR_LOADER_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT_LOAD and WAIT_STORE; it resets on each state entry.
  - When it reaches TIMEOUT_CYCLES: set timeout_err (sticky until reset), clear both masks, return to IDLE.
- When not defined:
  - No counter; the block waits indefinitely.
  - timeout_err is tied 0.

Test Plan:
- Write A = {1,2,3,4}, B = {5,6,7,8}, then start_req -> start_ack one cycle later; tensor_load_start the next cycle; data_out_a/b = 1/5, 2/6, 3/7, 4/8 on the four following cycles; busy = 1 throughout.
- Write A[0..3] and only B[0..2], then start_req -> start_nack pulse; no tensor_load_start; busy stays 0; then write B[3] and start_req -> normal launch.
- Hold tensor_load_done = 1 during STREAM, then tensor_store_done two cycles later -> load_done is latched; IDLE reached; busy = 0; operands_full = 0; wr_ready = 1.
- Attempt a write and start_req while busy -> wr_ready = 0; buffer unchanged; no second start_ack.
- Assert reset during STREAM at element 2 -> next cycle all outputs 0; state IDLE; operands_full = 0.
- With TENSOR_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, never assert tensor_load_done -> timeout_err = 1 after 8 WAIT_LOAD cycles; return to IDLE; flag persists until reset.

Source files
------------

// File: rtl/tensor_operand_loader.sv
// Operand staging buffer and streamer feeding the tensor unit's A/B inputs.
// Optional completion-wait timeout is enabled by defining TENSOR_LOADER_TIMEOUT_EN.
module tensor_operand_loader #(
  parameter int NUM_ELEMS      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  input  logic                         wr_sel,
  input  logic [$clog2(NUM_ELEMS)-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  input  logic                         start_req,
  output logic                         start_ack,
  output logic                         start_nack,
  output logic                         busy,
  output logic                         operands_full,
  output logic                         tensor_load_start,
  output logic [DATA_WIDTH-1:0]        data_out_a,
  output logic [DATA_WIDTH-1:0]        data_out_b,
  input  logic                         tensor_load_done,
  input  logic                         tensor_store_done,
  output logic                         timeout_err
);

  localparam int IW = $clog2(NUM_ELEMS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEMS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    STREAM     = 3'd2,
    WAIT_LOAD  = 3'd3,
    WAIT_STORE = 3'd4
  } state_t;

  state_t                state;
  logic [IW-1:0]         k;
  logic [NUM_ELEMS-1:0]  mask_a;
  logic [NUM_ELEMS-1:0]  mask_b;
  logic [NUM_ELEMS-1:0]  mask_a_nxt;
  logic [NUM_ELEMS-1:0]  mask_b_nxt;
  logic                  load_seen;
  logic                  store_seen;
  logic                  wr_fire;
  logic                  load_adv;
  logic                  store_adv;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] buf_a [NUM_ELEMS];
  logic [DATA_WIDTH-1:0] buf_b [NUM_ELEMS];

  // Handshake qualifiers; done pulses that arrived early count through the latches.
  always_comb begin
    wr_fire   = wr_valid && wr_ready;
    load_adv  = (state == WAIT_LOAD) && (tensor_load_done || load_seen);
    store_adv = (state == WAIT_STORE) && (tensor_store_done || store_seen);
  end

  // Written-mask update: completion or timeout clears, an accepted write sets a bit.
  always_comb begin
    mask_a_nxt = mask_a;
    mask_b_nxt = mask_b;
    if (store_adv || timeout_hit) begin
      mask_a_nxt = '0;
      mask_b_nxt = '0;
    end else if (wr_fire) begin
      if (wr_sel) begin
        mask_b_nxt[wr_idx] = 1'b1;
      end else begin
        mask_a_nxt[wr_idx] = 1'b1;
      end
    end else begin
      mask_a_nxt = mask_a;
      mask_b_nxt = mask_b;
    end
  end

  // Staging buffer storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_sel) begin
        buf_b[wr_idx] <= wr_data;
      end else begin
        buf_a[wr_idx] <= wr_data;
      end
    end
  end

`ifdef TENSOR_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;

  always_comb begin
    timeout_hit = (((state == WAIT_LOAD) && !load_adv) ||
                   ((state == WAIT_STORE) && !store_adv)) && (tcnt == TLIM);
  end

  // Wait-cycle counter restarts on every wait-state entry; error flag is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      if ((state == WAIT_LOAD || state == WAIT_STORE) && !load_adv && !store_adv && !timeout_hit) begin
        tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Main control FSM with all handshake and stream outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      k                 <= '0;
      mask_a            <= '0;
      mask_b            <= '0;
      operands_full     <= 1'b0;
      wr_ready          <= 1'b0;
      start_ack         <= 1'b0;
      start_nack        <= 1'b0;
      busy              <= 1'b0;
      tensor_load_start <= 1'b0;
      data_out_a        <= '0;
      data_out_b        <= '0;
      load_seen         <= 1'b0;
      store_seen        <= 1'b0;
    end else begin
      start_ack         <= 1'b0;
      start_nack        <= 1'b0;
      tensor_load_start <= 1'b0;
      data_out_a        <= '0;
      data_out_b        <= '0;
      mask_a            <= mask_a_nxt;
      mask_b            <= mask_b_nxt;
      operands_full     <= (&mask_a_nxt) & (&mask_b_nxt);
      case (state)
        IDLE: begin
          load_seen  <= 1'b0;
          store_seen <= 1'b0;
          k          <= '0;
          // Decision uses operands_full from before any same-cycle write.
          if (start_req && operands_full) begin
            start_ack <= 1'b1;
            busy      <= 1'b1;
            wr_ready  <= 1'b0;
            state     <= LAUNCH;
          end else begin
            start_nack <= start_req;
            wr_ready   <= 1'b1;
          end
        end
        LAUNCH: begin
          tensor_load_start <= 1'b1;
          k                 <= '0;
          load_seen         <= load_seen | tensor_load_done;
          store_seen        <= store_seen | tensor_store_done;
          state             <= STREAM;
        end
        STREAM: begin
          data_out_a <= buf_a[k];
          data_out_b <= buf_b[k];
          k          <= k + IW'(1);
          load_seen  <= load_seen | tensor_load_done;
          store_seen <= store_seen | tensor_store_done;
          if (k == LAST_IDX) begin
            state <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          store_seen <= store_seen | tensor_store_done;
          if (load_adv) begin
            state <= WAIT_STORE;
          end else if (timeout_hit) begin
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        WAIT_STORE: begin
          if (store_adv || timeout_hit) begin
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          busy     <= 1'b0;
          wr_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_operand_loader.sv
// Randomized self-checking bench for tensor_operand_loader against an array-based operand model.
module tb_tensor_operand_loader;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_sel = 1'b0;
  logic [1:0]    wr_idx = 2'd0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          start_req = 1'b0;
  logic          start_ack, start_nack, busy, operands_full, tensor_load_start;
  logic [DW-1:0] data_out_a, data_out_b;
  logic          tensor_load_done = 1'b0;
  logic          tensor_store_done = 1'b0;
  logic          timeout_err;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] ref_a [N];
  logic [DW-1:0] ref_b [N];
  bit            have_a [N];
  bit            have_b [N];

  tensor_operand_loader #(.NUM_ELEMS(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ready(wr_ready),
    .start_req(start_req), .start_ack(start_ack), .start_nack(start_nack),
    .busy(busy), .operands_full(operands_full), .tensor_load_start(tensor_load_start),
    .data_out_a(data_out_a), .data_out_b(data_out_b),
    .tensor_load_done(tensor_load_done), .tensor_store_done(tensor_store_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_full();
    bit f = 1'b1;
    for (int i = 0; i < N; i++) f = f & have_a[i] & have_b[i];
    return f;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      have_a[i] = 1'b0;
      have_b[i] = 1'b0;
    end
  endfunction

  // Drive one write for a cycle and record it in the model.
  task automatic write_elem(input bit sel, input int idx, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_sel = sel; wr_idx = 2'(idx); wr_data = d;
    step();
    wr_valid = 1'b0;
    if (sel) begin ref_b[idx] = d; have_b[idx] = 1'b1; end
    else begin ref_a[idx] = d; have_a[idx] = 1'b1; end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) write_elem(1'b0, i, $urandom);
    for (int i = 0; i < N; i++) write_elem(1'b1, i, $urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total++; if ({wr_ready, start_ack, start_nack, busy, operands_full, tensor_load_start, timeout_err} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000000", {wr_ready, start_ack, start_nack, busy, operands_full, tensor_load_start, timeout_err}); end
    total++; if ({data_out_a, data_out_b} !== 64'd0) begin bad++; $display("FAIL reset_data got=%h want=0", {data_out_a, data_out_b}); end
    model_clear();
    step();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL idle_wr_ready got=%b want=1", wr_ready); end
  endtask

  task automatic test_stream();
    write_elem(1'b0, 0, 32'd1); write_elem(1'b0, 1, 32'd2); write_elem(1'b0, 2, 32'd3); write_elem(1'b0, 3, 32'd4);
    write_elem(1'b1, 0, 32'd5); write_elem(1'b1, 1, 32'd6); write_elem(1'b1, 2, 32'd7); write_elem(1'b1, 3, 32'd8);
    total++; if (operands_full !== model_full()) begin bad++; $display("FAIL full_flag got=%b want=%b", operands_full, model_full()); end
    for (int rep = 0; rep < 3; rep++) begin
      if (rep > 0) fill_random();
      start_req = 1'b1; step(); start_req = 1'b0;
      total++; if ({start_ack, start_nack, busy, wr_ready, tensor_load_start} !== 5'b10100) begin
        bad++; $display("FAIL ack_cycle got=%b want=10100", {start_ack, start_nack, busy, wr_ready, tensor_load_start}); end
      step();
      total++; if ({tensor_load_start, start_ack, busy} !== 3'b101) begin
        bad++; $display("FAIL launch_cycle got=%b want=101", {tensor_load_start, start_ack, busy}); end
      for (int j = 0; j < N; j++) begin
        step();
        total++; if ({data_out_a, data_out_b, busy, tensor_load_start} !== {ref_a[j], ref_b[j], 2'b10}) begin
          bad++; $display("FAIL stream_elem%0d got=%h/%h busy=%b want=%h/%h", j, data_out_a, data_out_b, busy, ref_a[j], ref_b[j]); end
      end
      tensor_load_done = 1'b1; step(); tensor_load_done = 1'b0;
      total++; if ({data_out_a, data_out_b, busy} !== {64'd0, 1'b1}) begin
        bad++; $display("FAIL post_stream got=%h busy=%b want=0 busy=1", {data_out_a, data_out_b}, busy); end
      tensor_store_done = 1'b1; step(); tensor_store_done = 1'b0;
      model_clear();
      total++; if ({busy, operands_full, wr_ready} !== {1'b0, model_full(), 1'b1}) begin
        bad++; $display("FAIL return_idle got=%b want=0%b1", {busy, operands_full, wr_ready}, model_full()); end
    end
  endtask

  task automatic test_nack();
    for (int i = 0; i < N; i++) write_elem(1'b0, i, $urandom);
    for (int i = 0; i < N - 1; i++) write_elem(1'b1, i, $urandom);
    start_req = 1'b1; step(); start_req = 1'b0;
    total++; if ({start_nack, start_ack, busy} !== {~model_full(), 2'b00}) begin
      bad++; $display("FAIL nack_pulse got=%b want=100", {start_nack, start_ack, busy}); end
    step();
    total++; if ({start_nack, tensor_load_start, busy} !== 3'b000) begin
      bad++; $display("FAIL nack_quiet got=%b want=000", {start_nack, tensor_load_start, busy}); end
    // Completing write and start in one cycle: start sees the pre-write state.
    begin
      bit pre_full = model_full();
      start_req = 1'b1;
      write_elem(1'b1, N - 1, $urandom);
      start_req = 1'b0;
      total++; if ({start_ack, start_nack, operands_full} !== {pre_full, ~pre_full, model_full()}) begin
        bad++; $display("FAIL same_cycle got=%b want=%b%b%b", {start_ack, start_nack, operands_full}, pre_full, ~pre_full, model_full()); end
    end
    start_req = 1'b1; step(); start_req = 1'b0;
    total++; if ({start_ack, start_nack} !== {model_full(), ~model_full()}) begin
      bad++; $display("FAIL relaunch_ack got=%b want=10", {start_ack, start_nack}); end
    step();
    total++; if (tensor_load_start !== 1'b1) begin bad++; $display("FAIL relaunch_tls got=%b want=1", tensor_load_start); end
    for (int j = 0; j < N; j++) begin
      step();
      total++; if ({data_out_a, data_out_b} !== {ref_a[j], ref_b[j]}) begin
        bad++; $display("FAIL relaunch_elem%0d got=%h/%h want=%h/%h", j, data_out_a, data_out_b, ref_a[j], ref_b[j]); end
    end
    tensor_load_done = 1'b1; step(); tensor_load_done = 1'b0;
    tensor_store_done = 1'b1; step(); tensor_store_done = 1'b0;
    model_clear();
  endtask

  task automatic test_latched_done();
    bit left_busy;
    fill_random();
    start_req = 1'b1; step(); start_req = 1'b0;
    step();
    tensor_load_done = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (j == N - 1) tensor_load_done = 1'b0;
      step();
    end
    step();
    tensor_store_done = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_store_busy got=%b want=1", busy); end
    tensor_store_done = 1'b1; step(); tensor_store_done = 1'b0;
    model_clear();
    left_busy = busy;
    total++; if ({left_busy, operands_full, wr_ready} !== {1'b0, model_full(), 1'b1}) begin
      bad++; $display("FAIL latched_done_idle got=%b want=001", {left_busy, operands_full, wr_ready}); end
  endtask

  task automatic test_busy_block();
    int acks = 0;
    fill_random();
    start_req = 1'b1; step();
    wr_valid = 1'b1; wr_sel = 1'b0; wr_idx = 2'd0; wr_data = ~ref_a[0];
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL busy_wr_ready got=%b want=0", wr_ready); end
    step();
    for (int j = 0; j < N; j++) begin
      if (start_ack) acks++;
      step();
      total++; if ({data_out_a, data_out_b} !== {ref_a[j], ref_b[j]}) begin
        bad++; $display("FAIL busy_elem%0d got=%h/%h want=%h/%h", j, data_out_a, data_out_b, ref_a[j], ref_b[j]); end
    end
    wr_valid = 1'b0; start_req = 1'b0;
    total++; if (acks !== 0) begin bad++; $display("FAIL second_ack got=%0d want=0", acks); end
    tensor_load_done = 1'b1; step(); tensor_load_done = 1'b0;
    tensor_store_done = 1'b1; step(); tensor_store_done = 1'b0;
    model_clear();
  endtask

  task automatic test_reset_mid();
    fill_random();
    start_req = 1'b1; step(); start_req = 1'b0;
    step();
    for (int j = 0; j < 3; j++) step();
    total++; if (data_out_a !== ref_a[2]) begin bad++; $display("FAIL pre_reset_elem2 got=%h want=%h", data_out_a, ref_a[2]); end
    reset = 1'b1; step(); reset = 1'b0;
    model_clear();
    total++; if ({wr_ready, start_ack, start_nack, busy, operands_full, tensor_load_start, timeout_err, data_out_a, data_out_b} !== 71'd0) begin
      bad++; $display("FAIL mid_reset got=%b %h %h want=0", {wr_ready, start_ack, start_nack, busy, operands_full, tensor_load_start, timeout_err}, data_out_a, data_out_b); end
    step();
    start_req = 1'b1; step(); start_req = 1'b0;
    total++; if ({start_nack, busy, wr_ready} !== {~model_full(), 1'b0, 1'b1}) begin
      bad++; $display("FAIL after_reset_idle got=%b want=101", {start_nack, busy, wr_ready}); end
  endtask

`ifdef TENSOR_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    fill_random();
    start_req = 1'b1; step(); start_req = 1'b0;
    step();
    for (int j = 0; j < N; j++) step();
    for (int c = 1; c < 8; c++) step();
    total++; if ({timeout_err, busy} !== 2'b01) begin bad++; $display("FAIL timeout_early got=%b want=01", {timeout_err, busy}); end
    step();
    model_clear();
    total++; if ({timeout_err, busy, operands_full} !== {2'b10, model_full()}) begin
      bad++; $display("FAIL timeout_hit got=%b want=100", {timeout_err, busy, operands_full}); end
    start_req = 1'b1; step(); start_req = 1'b0;
    step(); step();
    total++; if ({timeout_err, busy} !== 2'b10) begin bad++; $display("FAIL timeout_sticky got=%b want=10", {timeout_err, busy}); end
    reset = 1'b1; step(); reset = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", timeout_err); end
    step();
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_stream();
    test_nack();
    test_latched_done();
    test_busy_block();
    test_reset_mid();
`ifdef TENSOR_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
